// File: rtl/decoder_scan_nx2n.sv
// Registered N-to-2^N one-hot decoder with a scan sequencer.
// DIRECT mode decodes A onto D with one cycle of latency. SCAN mode walks
// the outputs upward from the entry value of A, holding each one for DWELL
// cycles, and pulses wrap when the index rolls over to 0.
// Legal parameter range: 1 <= N <= 5, DWELL >= 1.
module decoder_scan_nx2n #(
    parameter int N          = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        A,
    output logic [(1<<N)-1:0]   D,
    output logic [N-1:0]        scan_idx,
    output logic                wrap
);

    localparam int W  = 1 << N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [W-1:0]  INACTIVE   = {W{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  d_q, d_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic          wrap_q, wrap_d;
    logic [N-1:0]  idx_inc;

    // One-hot pattern for an index, with the output polarity applied.
    function automatic logic [W-1:0] drive(input logic [N-1:0] idx);
        logic [W-1:0] oh;
        oh = W'(1) << idx;
        return ACTIVE_LOW ? ~oh : oh;
    endfunction

    assign idx_inc = idx_q + N'(1);

    // Next-state and next-output selection; en=0 wins over mode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;

        if (!en) begin
            state_d = ST_OFF;
            d_d     = INACTIVE;
            dwell_d = '0;
        end else if (!mode) begin
            state_d = ST_DIRECT;
            d_d     = drive(A);
            idx_d   = A;
            dwell_d = '0;
        end else if (state_q != ST_SCAN) begin
            // Scan entry restarts from the current A; no wrap even if A is 0.
            state_d = ST_SCAN;
            d_d     = drive(A);
            idx_d   = A;
            dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            idx_d   = idx_inc;
            d_d     = drive(idx_inc);
            wrap_d  = (idx_q == '1);
        end else begin
            dwell_d = dwell_q + CW'(1);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= ST_OFF;
            d_q     <= INACTIVE;
            idx_q   <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
        end
    end

    assign D        = d_q;
    assign scan_idx = idx_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
// Testbench for decoder_scan_nx2n: two instances (N=2/DWELL=3/active-high and
// N=3/DWELL=1/active-low), a behavioural reference model feeding a scoreboard
// queue per instance, plus literal checks of the key sequences.
module tb_decoder_scan_nx2n;

    logic       clk = 1'b0;
    // Instance a: N=2, DWELL=3, ACTIVE_LOW=0
    logic       rst_a = 1'b0, en_a = 1'b0, mode_a = 1'b0;
    logic [1:0] a_a = '0;
    logic [3:0] d_a;
    logic [1:0] idx_a;
    logic       wrap_a;
    // Instance b: N=3, DWELL=1, ACTIVE_LOW=1
    logic       rst_b = 1'b0, en_b = 1'b0, mode_b = 1'b0;
    logic [2:0] a_b = '0;
    logic [7:0] d_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int st;    // 0 off, 1 direct, 2 scan
        int idx;
        int left;  // cycles the current index still has to be shown
        int d;
        int wrap;
    } model_t;

    typedef struct {
        int d;
        int idx;
        int wrap;
    } exp_t;

    model_t ma = '{0, 0, 0, 0, 0};
    model_t mb = '{0, 0, 0, 255, 0};
    exp_t   q_a[$];
    exp_t   q_b[$];

    always #5 clk = ~clk;

    decoder_scan_nx2n #(.N(2), .DWELL(3), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_a), .en(en_a), .mode(mode_a), .A(a_a),
        .D(d_a), .scan_idx(idx_a), .wrap(wrap_a)
    );

    decoder_scan_nx2n #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_b), .en(en_b), .mode(mode_b), .A(a_b),
        .D(d_b), .scan_idx(idx_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pattern(input int idx, input int n, input bit al);
        int mask;
        int oh;
        mask = (1 << (1 << n)) - 1;
        oh   = 1 << idx;
        return al ? (~oh & mask) : oh;
    endfunction

    // Reference behaviour after one rising edge with the given inputs.
    function automatic model_t model_next(input model_t m, input int n, input int dwell,
                                          input bit al, input bit rst, input bit en,
                                          input bit mode, input int a);
        model_t r;
        int inactive;
        r        = m;
        r.wrap   = 0;
        inactive = al ? ((1 << (1 << n)) - 1) : 0;
        if (!rst) begin
            r.st = 0; r.idx = 0; r.left = 0; r.d = inactive;
        end else if (!en) begin
            r.st = 0; r.d = inactive;
        end else if (!mode) begin
            r.st = 1; r.idx = a; r.d = pattern(a, n, al);
        end else if (m.st != 2) begin
            r.st = 2; r.idx = a; r.left = dwell; r.d = pattern(a, n, al);
        end else if (m.left > 1) begin
            r.left = m.left - 1;
        end else begin
            r.idx  = (m.idx + 1) % (1 << n);
            r.left = dwell;
            r.d    = pattern(r.idx, n, al);
            r.wrap = (r.idx == 0) ? 1 : 0;
        end
        return r;
    endfunction

    // Push expectations for the coming edge, clock once, then compare.
    task automatic step();
        exp_t e;
        ma = model_next(ma, 2, 3, 1'b0, rst_a, en_a, mode_a, int'(a_a));
        mb = model_next(mb, 3, 1, 1'b1, rst_b, en_b, mode_b, int'(a_b));
        q_a.push_back('{ma.d, ma.idx, ma.wrap});
        q_b.push_back('{mb.d, mb.idx, mb.wrap});
        @(posedge clk);
        #1;
        e = q_a.pop_front();
        check("a_D", 32'(d_a), 32'(e.d));
        check("a_idx", 32'(idx_a), 32'(e.idx));
        check("a_wrap", 32'(wrap_a), 32'(e.wrap));
        e = q_b.pop_front();
        check("b_D", 32'(d_b), 32'(e.d));
        check("b_idx", 32'(idx_b), 32'(e.idx));
        check("b_wrap", 32'(wrap_b), 32'(e.wrap));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] scan_d [12];
        logic       scan_w [12];
        int         wraps;

        scan_d = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100,
                   4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
        scan_w = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

        // Reset held for two edges while enabled in scan mode.
        rst_a = 1'b0; en_a = 1'b1; mode_a = 1'b1; a_a = 2'd2;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_D", 32'(d_a), 32'h0);
            check("rst_idx", 32'(idx_a), 32'h0);
        end
        rst_a = 1'b1;
        step();
        check("rel_D", 32'(d_a), 32'b0100);

        // Direct sweep.
        mode_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_a = 2'(i);
            step();
            check("dir_D", 32'(d_a), 32'(1 << i));
        end
        en_a = 1'b0;
        step();
        check("off_D", 32'(d_a), 32'h0);

        // Scan from A=1; A wiggles after entry and must be ignored.
        en_a = 1'b1; mode_a = 1'b1; a_a = 2'd1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("scan_D", 32'(d_a), 32'(scan_d[i]));
            check("scan_wrap", 32'(wrap_a), 32'(scan_w[i]));
            a_a = 2'($urandom_range(0, 3));
        end

        // Walk to the middle of index 3's dwell, then interrupt.
        for (int i = 0; i < 8; i++) step();
        check("mid3_D", 32'(d_a), 32'b1000);
        mode_a = 1'b0; a_a = 2'd1;
        step();
        check("int_dir_D", 32'(d_a), 32'b0010);
        mode_a = 1'b1; a_a = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reent_D", 32'(d_a), 32'b1000);
        end
        step();
        check("reent_adv_D", 32'(d_a), 32'b0001);
        check("reent_wrap", 32'(wrap_a), 32'h1);
        step();
        en_a = 1'b0;
        step();
        check("en_off_D", 32'(d_a), 32'h0);

        // Synchronous reset mid-scan.
        en_a = 1'b1; mode_a = 1'b1; a_a = 2'd3;
        step();
        rst_a = 1'b0;
        #3;
        check("pre_edge_D", 32'(d_a), 32'b1000);
        step();
        check("mrst_D", 32'(d_a), 32'h0);
        check("mrst_idx", 32'(idx_a), 32'h0);
        check("mrst_wrap", 32'(wrap_a), 32'h0);
        rst_a = 1'b1;

        // Random traffic on instance a against the model.
        for (int i = 0; i < 40; i++) begin
            en_a   = ($urandom_range(0, 7) != 0);
            mode_a = ($urandom_range(0, 3) != 0);
            a_a    = 2'($urandom_range(0, 3));
            step();
        end

        // Instance b: N=3, DWELL=1, active-low, scan from A=6.
        en_a = 1'b0;
        step();
        rst_b = 1'b1; en_b = 1'b1; mode_b = 1'b1; a_b = 3'd6;
        wraps = 0;
        for (int i = 0; i < 19; i++) begin
            step();
            if (i == 0) check("b_D0", 32'(d_b), 32'hBF);
            if (i == 1) check("b_D1", 32'(d_b), 32'h7F);
            if (i == 2) check("b_D2", 32'(d_b), 32'hFE);
            if (wrap_b === 1'b1) wraps++;
            a_b = 3'($urandom_range(0, 7));
        end
        check("b_wrap_count", 32'(wraps), 32'd3);
        en_b = 1'b0;
        step();
        check("b_off_D", 32'(d_b), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
